// File: rtl/gray_pkg.sv
// Shared gray-code helpers and default width for gray_counter / gray_sync_decoder.
package gray_pkg;

  localparam int unsigned GRAY_DEFAULT_WIDTH = 8;
  // Widest count the helper functions handle; narrower values are zero-extended.
  localparam int unsigned GRAY_MAX_WIDTH     = 32;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = int'(GRAY_MAX_WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to gray.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchroniser for a gray-coded bus; kept as its own module so CDC and
// timing constraints can target it by name. Synchronous active-low reset.
module gray_sync_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("gray_sync_chain: STAGES must be at least 2");
  end

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the chain every cycle; reset discards all in-flight samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronises a gray count into clk, decodes it to binary and reports the advance
// since the last enabled update. Optional sticky multi-bit-transition checker is
// built when GRAY_SYNC_ERR_CHECK_EN is defined; otherwise err is tied low.
module gray_sync_decoder
  import gray_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = GRAY_DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] gray_in,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic [DATA_WIDTH-1:0] delta,
  output logic                  changed,
  output logic                  err,
  input  logic                  err_clr
);

  logic [DATA_WIDTH-1:0] dec_c;
  logic [DATA_WIDTH-1:0] bin_q,   bin_d;
  logic [DATA_WIDTH-1:0] delta_q, delta_d;
  logic                  changed_q, changed_d;

  gray_sync_chain #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (gray_in),
    .q_o   (gray_out)
  );

  // Combinational decode of the synchronised gray value.
  assign dec_c = DATA_WIDTH'(gray2bin(GRAY_MAX_WIDTH'(gray_out)));

  // Next-state for the update registers; hold cycles keep bin/delta and drop changed.
  always_comb begin
    bin_d     = bin_q;
    delta_d   = delta_q;
    changed_d = 1'b0;
    if (en) begin
      bin_d     = dec_c;
      delta_d   = dec_c - bin_q;
      changed_d = (dec_c != bin_q);
    end
  end

  // Update registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q     <= '0;
      delta_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      delta_q   <= delta_d;
      changed_q <= changed_d;
    end
  end

  assign bin_out = bin_q;
  assign delta   = delta_q;
  assign changed = changed_q;

`ifdef GRAY_SYNC_ERR_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] diff_c;
  logic                  multi_c;
  logic                  err_q, err_d;

  // More than one bit set in the change mask means a non-gray step was seen.
  assign diff_c  = gray_out ^ prev_q;
  assign multi_c = (diff_c & (diff_c - DATA_WIDTH'(1))) != '0;

  // Sticky flag; a detection in the same cycle as a clear keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (multi_c) err_d = 1'b1;
  end

  // Previous synchronised value and the error flag, tracked regardless of en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= gray_out;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (DATA_WIDTH=8, SYNC_STAGES=2).
module tb_gray_sync_decoder;

`ifdef GRAY_SYNC_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] gray_in;
  logic [7:0] gray_out;
  logic [7:0] bin_out;
  logic [7:0] delta;
  logic       changed;
  logic       err;
  logic       err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  gray_sync_decoder #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .gray_in  (gray_in),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .delta    (delta),
    .changed  (changed),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; err_clr = 1'b0; gray_in = 8'hFF;
    repeat (3) tick;
    n_checks++; if (gray_out !== 8'h00) begin n_fail++; $display("FAIL reset_gray_out got %h exp 00", gray_out); end
    n_checks++; if (bin_out !== 8'h00) begin n_fail++; $display("FAIL reset_bin_out got %h exp 00", bin_out); end
    n_checks++; if (delta !== 8'h00) begin n_fail++; $display("FAIL reset_delta got %h exp 00", delta); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got %b exp 0", changed); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 1'b1;
    tick;
    n_checks++; if (gray_out !== 8'h00) begin n_fail++; $display("FAIL rel1_gray_out got %h exp 00", gray_out); end
    tick;
    n_checks++; if (gray_out !== 8'hFF) begin n_fail++; $display("FAIL rel2_gray_out got %h exp FF", gray_out); end
    n_checks++; if (bin_out !== 8'h00) begin n_fail++; $display("FAIL rel2_bin_out got %h exp 00", bin_out); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL rel2_changed got %b exp 0", changed); end
    tick;
    n_checks++; if (bin_out !== 8'hAA) begin n_fail++; $display("FAIL rel3_bin_out got %h exp AA", bin_out); end
    n_checks++; if (delta !== 8'hAA) begin n_fail++; $display("FAIL rel3_delta got %h exp AA", delta); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL rel3_changed got %b exp 1", changed); end
    tick;
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL rel4_changed got %b exp 0", changed); end
    n_checks++; if (delta !== 8'h00) begin n_fail++; $display("FAIL rel4_delta got %h exp 00", delta); end
    n_checks++; if (bin_out !== 8'hAA) begin n_fail++; $display("FAIL rel4_bin_out got %h exp AA", bin_out); end
  endtask

  task automatic test_count;
    logic [7:0] g  [4];
    logic [7:0] eb [4];
    logic [7:0] ed [4];
    g[0] = 8'h00; g[1] = 8'h01; g[2] = 8'h03; g[3] = 8'h02;
    eb[0] = 8'h00; eb[1] = 8'h01; eb[2] = 8'h02; eb[3] = 8'h03;
    // First step comes from bin AA, so it wraps: 00 - AA = 56.
    ed[0] = 8'h56; ed[1] = 8'h01; ed[2] = 8'h01; ed[3] = 8'h01;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) gray_in = g[k];
      tick;
      if (k >= 2) begin
        n_checks++; if (bin_out !== eb[k-2]) begin n_fail++; $display("FAIL count_bin[%0d] got %h exp %h", k-2, bin_out, eb[k-2]); end
        n_checks++; if (delta !== ed[k-2]) begin n_fail++; $display("FAIL count_delta[%0d] got %h exp %h", k-2, delta, ed[k-2]); end
        n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL count_changed[%0d] got %b exp 1", k-2, changed); end
      end
    end
    tick;
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL count_hold_changed got %b exp 0", changed); end
    n_checks++; if (bin_out !== 8'h03) begin n_fail++; $display("FAIL count_hold_bin got %h exp 03", bin_out); end
  endtask

  task automatic test_wrap;
    gray_in = 8'h80;
    repeat (3) tick;
    n_checks++; if (bin_out !== 8'hFF) begin n_fail++; $display("FAIL wrap_top_bin got %h exp FF", bin_out); end
    n_checks++; if (delta !== 8'hFC) begin n_fail++; $display("FAIL wrap_top_delta got %h exp FC", delta); end
    tick;
    gray_in = 8'h00;
    repeat (3) tick;
    n_checks++; if (bin_out !== 8'h00) begin n_fail++; $display("FAIL wrap_bin got %h exp 00", bin_out); end
    n_checks++; if (delta !== 8'h01) begin n_fail++; $display("FAIL wrap_delta got %h exp 01", delta); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL wrap_changed got %b exp 1", changed); end
  endtask

  task automatic test_hold;
    logic [7:0] g [4];
    g[0] = 8'h05; g[1] = 8'h04; g[2] = 8'h0C; g[3] = 8'h0D; // bin 6,7,8,9
    gray_in = 8'h07; // bin 5
    repeat (4) tick;
    n_checks++; if (bin_out !== 8'h05) begin n_fail++; $display("FAIL hold_start_bin got %h exp 05", bin_out); end
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) gray_in = g[k];
      tick;
      n_checks++; if (bin_out !== 8'h05) begin n_fail++; $display("FAIL hold_bin[%0d] got %h exp 05", k, bin_out); end
      n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL hold_changed[%0d] got %b exp 0", k, changed); end
      n_checks++; if (delta !== 8'h00) begin n_fail++; $display("FAIL hold_delta[%0d] got %h exp 00", k, delta); end
    end
    en = 1'b1;
    tick;
    n_checks++; if (bin_out !== 8'h09) begin n_fail++; $display("FAIL hold_resume_bin got %h exp 09", bin_out); end
    n_checks++; if (delta !== 8'h04) begin n_fail++; $display("FAIL hold_resume_delta got %h exp 04", delta); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL hold_resume_changed got %b exp 1", changed); end
    tick;
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL hold_single_pulse got %b exp 0", changed); end
  endtask

  task automatic test_err;
    gray_in = 8'h00;
    repeat (3) tick;
    err_clr = 1'b1; tick; err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_initial_clear got %b exp 0", err); end
    gray_in = 8'h03;
    repeat (2) tick;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_early got %b exp 0", err); end
    tick;
    n_checks++; if (err !== ERR_EN) begin n_fail++; $display("FAIL err_set got %b exp %b", err, ERR_EN); end
    repeat (2) tick;
    n_checks++; if (err !== ERR_EN) begin n_fail++; $display("FAIL err_sticky got %b exp %b", err, ERR_EN); end
    err_clr = 1'b1; tick; err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
    gray_in = 8'h00;
    repeat (2) tick;
    err_clr = 1'b1; tick; err_clr = 1'b0;
    n_checks++; if (err !== ERR_EN) begin n_fail++; $display("FAIL err_set_wins got %b exp %b", err, ERR_EN); end
    tick;
    n_checks++; if (err !== ERR_EN) begin n_fail++; $display("FAIL err_after_set_wins got %b exp %b", err, ERR_EN); end
    err_clr = 1'b1; tick; err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_final_clear got %b exp 0", err); end
    n_checks++; if (bin_out !== 8'h00) begin n_fail++; $display("FAIL err_bin got %h exp 00", bin_out); end
  endtask

  task automatic test_mid_reset;
    gray_in = 8'h01; tick;
    gray_in = 8'h03; tick;
    gray_in = 8'h02; tick;
    n_checks++; if (bin_out !== 8'h01) begin n_fail++; $display("FAIL mid_pre_bin got %h exp 01", bin_out); end
    rst = 1'b0; gray_in = 8'h06; // bin 4
    tick;
    rst = 1'b1;
    n_checks++; if (gray_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_gray_out got %h exp 00", gray_out); end
    n_checks++; if (bin_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_bin got %h exp 00", bin_out); end
    n_checks++; if (delta !== 8'h00) begin n_fail++; $display("FAIL mid_rst_delta got %h exp 00", delta); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL mid_rst_changed got %b exp 0", changed); end
    tick;
    n_checks++; if (gray_out !== 8'h00) begin n_fail++; $display("FAIL mid_r1_gray_out got %h exp 00", gray_out); end
    tick;
    n_checks++; if (gray_out !== 8'h06) begin n_fail++; $display("FAIL mid_r2_gray_out got %h exp 06", gray_out); end
    n_checks++; if (bin_out !== 8'h00) begin n_fail++; $display("FAIL mid_r2_bin got %h exp 00", bin_out); end
    tick;
    n_checks++; if (bin_out !== 8'h04) begin n_fail++; $display("FAIL mid_r3_bin got %h exp 04", bin_out); end
    n_checks++; if (delta !== 8'h04) begin n_fail++; $display("FAIL mid_r3_delta got %h exp 04", delta); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL mid_r3_changed got %b exp 1", changed); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; err_clr = 1'b0; gray_in = 8'h00;
    test_reset;
    test_count;
    test_wrap;
    test_hold;
    test_err;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
